// File: rtl/display_scheduler.sv
// display_scheduler: periodically samples value_in, runs one BCD conversion at a
// time over the converter's start/ready handshake, latches the four digits
// atomically and scans them onto a 4-digit multiplexed seven-segment display.
module display_scheduler #(
  parameter int REFRESH_DIV   = 1000,
  parameter int SAMPLE_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value_in,
  input  logic        enable,
  output logic        conv_start,
  output logic [13:0] conv_value,
  input  logic        conv_ready,
  input  logic [3:0]  conv_a,
  input  logic [3:0]  conv_b,
  input  logic [3:0]  conv_c,
  input  logic [3:0]  conv_d,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        valid
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (SAMPLE_FRAMES > 1) ? $clog2(SAMPLE_FRAMES) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SAMPLE_FRAMES - 1);
  localparam logic [3:0]    DASH       = 4'hE;
  localparam logic [13:0]   MAX_VAL    = 14'd9999;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_BUSY, S_LATCH} state_t;
  state_t state, state_nx;

  logic [RW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          ref_wrap;
  logic          tick;
  logic          pending;
  logic [1:0]    ack_cnt;
  logic [3:0]    d0, d1, d2, d3;
  logic          start_nx, latch_conv, latch_dash, pend_clr, pend_set;
  logic [3:0]    dig_p0;
  logic          blank_p0;

  // Digit code to active-low {g,f,e,d,c,b,a}; codes 10-14 show a dash, 15 is blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    if (blank) begin
      s = 7'h7F;
    end else begin
      case (d)
        4'd0:    s = 7'b1000000;
        4'd1:    s = 7'b1111001;
        4'd2:    s = 7'b0100100;
        4'd3:    s = 7'b0110000;
        4'd4:    s = 7'b0011001;
        4'd5:    s = 7'b0010010;
        4'd6:    s = 7'b0000010;
        4'd7:    s = 7'b1111000;
        4'd8:    s = 7'b0000000;
        4'd9:    s = 7'b0010000;
        4'hF:    s = 7'h7F;
        default: s = 7'b0111111;
      endcase
    end
    return s;
  endfunction

  assign ref_wrap = (ref_cnt == REF_LAST);
  assign tick     = ref_wrap && (idx == 2'd3) && (frame_cnt == FRAME_LAST);

  // Scan timing: per-digit dwell counter, digit index and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt   <= '0;
      idx       <= 2'd0;
      frame_cnt <= '0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
      if (idx == 2'd3)
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Handshake sequencing: next state and one-cycle action strobes.
  always_comb begin
    state_nx   = state;
    start_nx   = 1'b0;
    latch_conv = 1'b0;
    latch_dash = 1'b0;
    pend_clr   = 1'b0;
    pend_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          if (value_in > MAX_VAL) begin
            latch_dash = 1'b1;
            pend_clr   = 1'b1;
          end else if (conv_ready) begin
            start_nx = 1'b1;
            pend_clr = 1'b1;
            state_nx = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (!conv_ready) begin
          state_nx = S_BUSY;
        end else if (ack_cnt == 2'd2) begin
          // Converter never acknowledged: requeue the request and retry.
          pend_set = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_BUSY: begin
        if (conv_ready) state_nx = S_LATCH;
      end
      S_LATCH: begin
        latch_conv = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state: FSM register, ack timeout counter, request flag, converter port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ack_cnt    <= 2'd0;
      pending    <= 1'b0;
      conv_start <= 1'b0;
      conv_value <= '0;
    end else begin
      state      <= state_nx;
      ack_cnt    <= (state == S_ACK) ? ack_cnt + 2'd1 : 2'd0;
      conv_start <= start_nx;
      if (start_nx)
        conv_value <= value_in;
      // A tick arriving while a request is pending simply merges into it.
      if (pend_set || (tick && enable))
        pending <= 1'b1;
      else if (pend_clr)
        pending <= 1'b0;
    end
  end

  // Display registers: all four digits change together, from the converter or as dashes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d0    <= 4'hF;
      d1    <= 4'hF;
      d2    <= 4'hF;
      d3    <= 4'hF;
      valid <= 1'b0;
    end else if (latch_conv) begin
      d0    <= conv_a;
      d1    <= conv_b;
      d2    <= conv_c;
      d3    <= conv_d;
      valid <= 1'b1;
    end else if (latch_dash) begin
      d0    <= DASH;
      d1    <= DASH;
      d2    <= DASH;
      d3    <= DASH;
      valid <= 1'b1;
    end
  end

  // Select the scanned digit and apply leading-zero blanking (ones never blanked).
  always_comb begin
    dig_p0   = d0;
    blank_p0 = 1'b0;
    case (idx)
      2'd1: begin
        dig_p0   = d1;
        blank_p0 = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      end
      2'd2: begin
        dig_p0   = d2;
        blank_p0 = (d3 == 4'd0) && (d2 == 4'd0);
      end
      2'd3: begin
        dig_p0   = d3;
        blank_p0 = (d3 == 4'd0);
      end
      default: begin
        dig_p0   = d0;
        blank_p0 = 1'b0;
      end
    endcase
  end

  // Registered scan outputs: one-hot active-low anode and its segment pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'hF;
      seg <= 7'h7F;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_of(dig_p0, blank_p0);
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed sequence with randomized values against a
// behavioural converter and an arithmetic model of the displayed digits.
module tb_display_scheduler;
  localparam int R  = 4;
  localparam int SF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] value_in = '0;
  logic        enable = 1'b0;
  logic        conv_start;
  logic [13:0] conv_value;
  logic        conv_ready = 1'b1;
  logic [3:0]  conv_a = '0, conv_b = '0, conv_c = '0, conv_d = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        valid;

  int total = 0;
  int bad   = 0;

  display_scheduler #(.REFRESH_DIV(R), .SAMPLE_FRAMES(SF)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .enable(enable),
    .conv_start(conv_start), .conv_value(conv_value), .conv_ready(conv_ready),
    .conv_a(conv_a), .conv_b(conv_b), .conv_c(conv_c), .conv_d(conv_d),
    .an(an), .seg(seg), .valid(valid)
  );

  always #5 clk = ~clk;

  // Behavioural converter: accepts a start while idle, drops ready, answers after lat cycles.
  int          lat = 20;
  bit          ignore_start = 1'b0;
  bit          cv_busy = 1'b0;
  int          cv_cnt = 0;
  int          cv_val = 0;
  int          start_cnt = 0;
  int          width_err = 0;
  bit          start_prev = 1'b0;

  always @(posedge clk) begin
    if (conv_start) begin
      start_cnt <= start_cnt + 1;
      if (start_prev) width_err <= width_err + 1;
    end
    start_prev <= conv_start;
    if (!cv_busy) begin
      if (conv_start && !ignore_start) begin
        cv_busy    <= 1'b1;
        cv_val     <= int'(conv_value);
        cv_cnt     <= lat;
        conv_ready <= 1'b0;
      end
    end else if (cv_cnt <= 1) begin
      cv_busy    <= 1'b0;
      conv_ready <= 1'b1;
      conv_a     <= 4'(cv_val % 10);
      conv_b     <= 4'((cv_val / 10) % 10);
      conv_c     <= 4'((cv_val / 100) % 10);
      conv_d     <= 4'((cv_val / 1000) % 10);
    end else begin
      cv_cnt <= cv_cnt - 1;
    end
  end

  logic [6:0] digit_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Expected pattern at position pos (0 = ones); v < 0 means nothing latched yet.
  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int p;
    p = 1;
    for (int k = 0; k < pos; k++) p = p * 10;
    if (v < 0) return 7'h7F;
    if (v > 9999) return 7'b0111111;
    if (pos > 0 && v < p) return 7'h7F;
    return digit_pat[(v / p) % 10];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_start(input int maxc, output bit ok, output logic [13:0] val);
    ok  = 1'b0;
    val = '0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        ok  = 1'b1;
        val = conv_value;
      end
    end
  endtask

  task automatic show_check(input int v, input string tag);
    bit found;
    for (int pos = 0; pos < 4; pos++) begin
      found = 1'b0;
      for (int i = 0; i < 4 * R + 8 && !found; i++) begin
        @(negedge clk);
        if (an === ~(4'b0001 << pos)) found = 1'b1;
      end
      chk({tag, "_an_seen"}, 32'(found), 32'd1);
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(v, pos)));
    end
  endtask

  task automatic run_conv(input int v, input string tag);
    bit ok;
    logic [13:0] cv;
    int s0;
    s0 = start_cnt;
    value_in = 14'(v);
    enable = 1'b1;
    wait_start(100, ok, cv);
    chk({tag, "_start_seen"}, 32'(ok), 32'd1);
    chk({tag, "_conv_value"}, 32'(cv), 32'(v));
    @(negedge clk);
    enable = 1'b0;
    repeat (lat + 20) @(negedge clk);
    chk({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    show_check(v, tag);
  endtask

  task automatic run_ovf(input int v, input string tag);
    int s0;
    s0 = start_cnt;
    value_in = 14'(v);
    enable = 1'b1;
    repeat (80) @(negedge clk);
    enable = 1'b0;
    chk({tag, "_no_start"}, 32'(start_cnt - s0), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    show_check(v, tag);
  endtask

  initial begin
    bit ok;
    logic [13:0] cv;
    int s0, gap, run;

    // Power-on reset, then assert reset again in the middle of a scan.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (13) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_start", 32'(conv_start), 32'd0);
    chk("rst_value", 32'(conv_value), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_an0", 32'(an), 32'hE);
    show_check(-1, "blank_after_rst");

    // Each anode dwells exactly R cycles.
    ok = 1'b0;
    for (int i = 0; i < 8 * R && !ok; i++) begin
      @(negedge clk);
      if (an === 4'b1101) ok = 1'b1;
    end
    run = 0;
    while (an === 4'b1101 && run < 4 * R) begin
      run++;
      @(negedge clk);
    end
    chk("dwell_an1", 32'(run), 32'(R));

    // Normal conversions, including blanking cases and random values.
    run_conv(1234, "v1234");
    run_conv(7, "v7");
    run_conv(0, "v0");
    for (int k = 0; k < 4; k++) run_conv(int'($urandom_range(0, 9999)), "vrand");

    // Overflow bypasses the converter.
    run_ovf(10000, "ovf10000");
    run_ovf(int'($urandom_range(10000, 16383)), "ovfrand");

    // Long conversion: ticks during it merge into one follow-up start.
    lat = 200;
    value_in = 14'($urandom_range(0, 9999));
    enable = 1'b1;
    s0 = start_cnt;
    wait_start(100, ok, cv);
    chk("hold_first_start", 32'(ok), 32'd1);
    @(negedge clk);
    lat = 5;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (conv_ready === 1'b1) ok = 1'b1;
    end
    chk("hold_ready_rise", 32'(ok), 32'd1);
    chk("hold_single_start", 32'(start_cnt - s0), 32'd1);
    wait_start(10, ok, cv);
    chk("hold_followup", 32'(ok), 32'd1);
    @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    chk("hold_total_starts", 32'(start_cnt - s0), 32'd2);
    show_check(int'(value_in), "hold");

    // Converter ignores the start: the scheduler retries shortly after.
    lat = 20;
    ignore_start = 1'b1;
    value_in = 14'($urandom_range(0, 9999));
    enable = 1'b1;
    wait_start(100, ok, cv);
    chk("ign_first_start", 32'(ok), 32'd1);
    gap = 0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      gap++;
      if (conv_start === 1'b1) ok = 1'b1;
    end
    chk("ign_retry_seen", 32'(ok), 32'd1);
    chk("ign_retry_gap", 32'(gap >= 3 && gap <= 5), 32'd1);
    ignore_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (lat + 20) @(negedge clk);
    s0 = start_cnt;
    show_check(int'(value_in), "ign");
    repeat (40) @(negedge clk);
    chk("ign_no_more_starts", 32'(start_cnt - s0), 32'd0);

    // Reset while the converter is busy clears the display and valid.
    lat = 40;
    value_in = 14'($urandom_range(1, 9999));
    enable = 1'b1;
    wait_start(100, ok, cv);
    chk("busy_start", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    #1;
    chk("busy_rst_an", 32'(an), 32'hF);
    chk("busy_rst_seg", 32'(seg), 32'h7F);
    chk("busy_rst_valid", 32'(valid), 32'd0);
    chk("busy_rst_start", 32'(conv_start), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    s0 = start_cnt;
    repeat (100) @(negedge clk);
    chk("busy_after_valid", 32'(valid), 32'd0);
    chk("busy_after_starts", 32'(start_cnt - s0), 32'd0);
    show_check(-1, "busy_after");

    chk("start_width", 32'(width_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequencing controller between a free-running 14-bit value source and the shared BCD converter (`bcd4digit`), and scan driver for the 4-digit multiplexed seven-segment display. It periodically samples `value_in`, issues one conversion at a time over the converter's start/ready handshake, latches the four digits atomically, and scans them onto the display with leading-zero blanking. Values above 9999 bypass the converter and show an overflow pattern.

## Interface
- `REFRESH_DIV`, default 1000: clk cycles each digit stays lit. Legal range is ≥2.
- `SAMPLE_FRAMES`, default 16: scan frames (4 digits each) between sample ticks. Legal range is ≥1.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `value_in`  in  14: binary value to display.
- `enable`  in  1: when low, no new conversions start and the display is frozen on its last contents.
- `conv_start`  out  1: one-cycle start pulse to the converter.
- `conv_value`  out  14: operand to the converter. Held stable from the start pulse until the result is latched.
- `conv_ready`  in  1: converter idle/result-valid.
- `conv_a`, `conv_b`, `conv_c`, `conv_d`  in  4 each: ones, tens, hundreds, thousands digits.
- `an`  out  4: digit anodes, one-hot, active-low. `an[0]` is the ones digit.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `valid`  out  1: high once the first result or overflow pattern has been latched.

## Operation
- **Reset values:**
  - `an`=4'hF, `seg`=7'h7F, `conv_start`=0, `conv_value`=0, `valid`=0.
  - Display registers = 4'hF (blank). Scan index 0, counters 0, `pending`=0, FSM in `S_IDLE`.
- **Sample tick:** one cycle, at the end of every `SAMPLE_FRAMES`-th frame. Sets `pending` if `enable`=1. Further ticks while pending merge into it; they are not queued.
- **`S_IDLE`:**
  - If `pending` and `value_in` > 9999: load all display registers with the dash code, clear `pending`, set `valid`, stay in `S_IDLE`.
  - Else if `pending` and `conv_ready`=1: register `value_in` into `conv_value`, pulse `conv_start`, clear `pending`, go to `S_ACK`.
  - Else if `pending` and `conv_ready`=0: wait in `S_IDLE`.
- **`S_ACK`:** wait for `conv_ready`=0, then go to `S_BUSY`. If `conv_ready` is still 1 after 3 cycles in `S_ACK`, set `pending` again and return to `S_IDLE` (retry).
- **`S_BUSY`:** wait for `conv_ready`=1, then go to `S_LATCH`.
- **`S_LATCH`:** copy `conv_a`..`conv_d` into all four display registers in the same cycle, set `valid`, go to `S_IDLE`.
- **`enable` falling mid-conversion:** the in-flight conversion completes and latches. Only new starts are blocked.
- **Digit code to segments:**
  - 0–9: standard patterns.
  - 4'hF: blank (7'h7F).
  - 10–14: dash (7'b0111111, i.e. g only). The dash code stored for overflow is 4'hE.
- **Leading-zero blanking (display only, registers unchanged):**
  - thousands is blanked if 0.
  - hundreds is blanked if it and thousands are 0.
  - tens is blanked if it, hundreds and thousands are 0.
  - ones is never blanked.
- **Scan:**
  - The counter counts 0..`REFRESH_DIV`-1; at wrap the digit index advances 0→1→2→3→0.
  - The frame counter advances when the index wraps 3→0.
  - `an` and `seg` are registered from the index and display registers.
- **Reset mid-operation:** all state returns to reset values immediately. No start pulse is emitted.

## Timing
- `conv_start` is exactly 1 cycle wide, asserted the cycle after `S_IDLE` sees `pending`=1 with `conv_ready`=1.
- `conv_value` changes only on the start cycle.
- The display registers update the cycle after `conv_ready` rises in `S_BUSY`. `seg` reflects the new value at the next registered scan output (+1 cycle).
- Overflow path: `seg` shows the dash at most `REFRESH_DIV`+1 cycles after the tick.
- Each anode stays low for exactly `REFRESH_DIV` cycles. There is no overlap: one `an` bit low at a time after reset.
- A sample tick and the `S_LATCH` cycle may coincide. The latch happens, then the new pending request starts from `S_IDLE`.

## Test plan
- **Reset:** assert `rst`=0 mid-scan → `an`=F, `seg`=7F, `conv_start`=0, `valid`=0. After release, the first anode (`an`=4'b1110) goes low within 1 cycle.
- **Normal conversion:** `value_in`=1234, model converter with 20-cycle latency → exactly one `conv_start` pulse with `conv_value`=1234. Ones digit shows 4 (7'b0011001), thousands shows 1. `valid`=1.
- **Blanking:** `value_in`=7 → thousands, hundreds and tens anodes show 7F; ones shows 7 (7'b1111000). `value_in`=0 → only the ones digit shows 0.
- **Overflow:** `value_in`=10000 → no `conv_start`; all four digits show 7'b0111111.
- **Handshake robustness:**
  - Converter holds `conv_ready`=0 for 200 cycles across several ticks → single start, ticks merged, exactly one follow-up start after latch.
  - Converter ignores the start (ready stays 1) → retry start after 3 cycles.
- **`enable` and mid-operation reset:**
  - `enable` dropped one cycle after `conv_start` → result still latched, no further starts.
  - `rst` pulsed in `S_BUSY` → display blank, `valid`=0.
